// File: rtl/mul_if.sv
// mul_if: start/operand/result bundle between M-extension control and the sequential multiplier.
interface mul_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  modport master (output start, op, rs1, rs2, input busy, done, result);
  modport slave (input start, op, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/mul_seq.sv
// mul_seq: radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU, one partial product per clock.
module mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic rst_n,
  mul_if.slave m
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mcand, hi, lo, result;
  logic [CNT_W-1:0] cnt;
  logic [1:0] op_q;
  logic neg, done;
  logic s1, s2, load, last;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] prod_nx, prod_fix;
  always_comb begin
    s1 = m.op == 2'b01 || m.op == 2'b10;
    s2 = m.op == 2'b01;
    mag1 = (s1 && m.rs1[WIDTH-1]) ? -m.rs1 : m.rs1;
    mag2 = (s2 && m.rs2[WIDTH-1]) ? -m.rs2 : m.rs2;
    load = state == IDLE && m.start;
    last = state == CALC && cnt == CNT_W'(WIDTH-1);
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    prod_nx = {sum, lo[WIDTH-1:1]};
    prod_fix = neg ? -prod_nx : prod_nx;
    state_nx = state == IDLE ? (m.start ? CALC : IDLE) : (last ? IDLE : CALC);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      op_q <= '0;
      neg <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else if (load) begin
      mcand <= mag1;
      lo <= mag2;
      hi <= '0;
      cnt <= '0;
      op_q <= m.op;
      neg <= (s1 & m.rs1[WIDTH-1]) ^ (s2 & m.rs2[WIDTH-1]);
      done <= 1'b0;
    end else if (state == CALC) begin
      {hi, lo} <= prod_nx;
      cnt <= cnt + 1'b1;
      done <= last;
      if (last) result <= op_q == 2'b00 ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end else begin
      done <= 1'b0;
    end
  end
  assign m.busy = state == CALC;
  assign m.done = done;
  assign m.result = result;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed and random checks of mul_seq against a full-width arithmetic product model.
module tb_mul_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] prev_res = '0;
  mul_if #(.WIDTH(32)) bus ();
  mul_seq #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .m(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    y = (o == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p = x * y;
    return o == 2'b00 ? p[31:0] : p[63:32];
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input bit poke);
    bus.start = 1'b1;
    bus.op = o;
    bus.rs1 = a;
    bus.rs2 = b;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.rs1 = $urandom;
      bus.rs2 = $urandom;
      if (poke && k == 10) begin
        bus.start = 1'b1;
        bus.rs1 = 32'd9;
        bus.rs2 = 32'd9;
      end
      chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
      chk({tag, "_nodone"}, {31'b0, bus.done}, 32'd0);
      chk({tag, "_held"}, bus.result, prev_res);
    end
    @(negedge clk);
    chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
    chk({tag, "_idle"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_result"}, bus.result, exp);
    prev_res = exp;
  endtask

  initial begin
    logic [1:0] o;
    logic [31:0] a, b;
    bit saw_done;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.rs1 = '0;
    bus.rs2 = '0;
    #12;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b0);
    @(negedge clk);
    chk("pulse_end", {31'b0, bus.done}, 32'd0);
    run("mulh_m1m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    run("mul_m1m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run("mulhu_m1m1", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run("mulhsu_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run("mulh_min1", 2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
    run("mul_min1", 2'b00, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0);
    @(negedge clk);
    run("mul_3x5", 2'b00, 32'd3, 32'd5, 32'h0000000F, 1'b1);
    run("mul_9x9", 2'b00, 32'd9, 32'd9, 32'h00000051, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.rs1 = 32'hDEADBEEF;
    bus.rs2 = 32'h12345678;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_done", {31'b0, bus.done}, 32'd0);
    chk("arst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      saw_done |= bus.done | bus.busy;
    end
    chk("arst_quiet", {31'b0, saw_done}, 32'd0);
    prev_res = '0;
    run("mul_2x3", 2'b00, 32'd2, 32'd3, 32'd6, 1'b0);
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = 32'h80000000;
      if (i % 4 == 2) b = 32'h80000000;
      if (i % 5 == 3) b = 32'd0;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run($sformatf("rnd%0d", i), o, a, b, model(o, a, b), 1'b0);
    end
    @(negedge clk);
    chk("final_done", {31'b0, bus.done}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
- It is the multiply-side counterpart of the bit-serial restoring divider: one partial product per clock, 32 iterations.
- It sits in the EX stage beside the divider. It is started by the M-extension control and stalls the pipeline while busy.
- Results are written back on the one-cycle done pulse.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a multiply; sampled on the rising edge
- op  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- rs1  input  WIDTH  multiplicand operand (rs1 value)
- rs2  input  WIDTH  multiplier operand (rs2 value)
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; result is valid in the same cycle
- result  output  WIDTH  selected product half; held until the next completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, counter=0, product register=0. Takes effect immediately, including mid-operation. The in-flight operation is discarded and no done is produced.
- States: IDLE and CALC. done is a separate registered flag, not a state.
- Operand signedness:
  - rs1 is treated as signed for MULH and MULHSU.
  - rs2 is treated as signed for MULH only.
  - MUL and MULHU treat both operands as unsigned; the low half is sign-independent.
- Load: in IDLE, start=1 at edge N does the following.
  - Latch mcand = |rs1| and lo = |rs2|, where |x| is the two's-complement magnitude if x is treated signed and negative, else x. |0x80000000| = 0x80000000, as unsigned.
  - Latch neg = sign(rs1 as treated) XOR sign(rs2 as treated).
  - Latch op, clear hi and counter, go to CALC.
  - done goes low at this edge.
- Iteration: each edge in CALC:
  - sum[WIDTH:0] = hi + (lo[0] ? mcand : 0), a 33-bit sum keeping the carry.
  - {hi, lo} <= {sum, lo} >> 1, i.e. the carry shifts into hi's MSB.
  - counter increments.
- Completion, at the edge where counter==WIDTH-1 (edge N+WIDTH):
  - Take the next-state 64-bit product P. If neg=1, P = ~P + 1, as a 64-bit two's-complement negate.
  - result <= P[WIDTH-1:0] for MUL, else P[2*WIDTH-1:WIDTH].
  - done <= 1 and state <= IDLE.
- Latency: start sampled at edge N. busy is high in the cycles after edges N..N+31. done and result are valid in the cycle after edge N+32, which is 32 cycles after acceptance.
- done is high for exactly one cycle and clears at the next edge unless that edge completes another operation (not possible, minimum spacing 32).
- start while busy (CALC) is ignored; operands are not re-latched.
- start in the done cycle is accepted, since the state is IDLE. This gives back-to-back operation with result still showing the previous value until the next completion.
- Operands need only be valid in the start cycle. No combinational path exists from start, rs1 or rs2 to busy, done or result.
- Overflow is impossible: |rs1|*|rs2| < 2^64 and fits in {hi, lo}.

Test Plan:
- MUL rs1=7, rs2=6, start at edge N -> busy high for 32 cycles; done single pulse after edge N+32; result=0x0000002A.
- MULH rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result=0x00000000. Same operands with MUL -> 0x00000001. Same operands with MULHU -> 0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF (unsigned) -> product 0xFFFFFFFF_00000001; result=0xFFFFFFFF. MULH rs1=0x80000000, rs2=0x80000000 -> result=0x40000000.
- MULH rs1=0x80000000, rs2=0x00000001 -> result=0xFFFFFFFF. MUL with the same operands -> 0x80000000.
- Start MUL 3*5. Pulse start again with 9*9 at cycle 10 of busy -> ignored, result=0x0000000F. Then assert start with 9*9 in the done cycle -> accepted; done 32 cycles later with result=0x00000051.
- Start MULHU, drop rst_n asynchronously mid-cycle at iteration 12 -> busy, done and result go to 0 immediately. No done pulse follows. After release, a new MUL 2*3 completes normally with result=6.
